// File: rtl/ats21_pkg.sv
// Shared types and helpers for the ats21 command path: opcodes, command pairs,
// sequencer states and the opcode sanitiser.
package ats21_pkg;

   typedef enum logic [2:0] {
      nop       = 3'b000,
      set_clk   = 3'b001,
      clk_en    = 3'b010,
      set_mode  = 3'b011,
      set_alarm = 3'b101,
      set_timer = 3'b110,
      at_en     = 3'b111
   } opcode_t;

   localparam int          OPC_HI     = 31;
   localparam int          OPC_LO     = 29;
   localparam logic [2:0]  OP_ILLEGAL = 3'b100;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } cmd_pair_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_UPPER,
      ST_LOWER
   } seq_state_t;

   function automatic logic is_illegal(input logic [31:0] cmd);
      return cmd[OPC_HI:OPC_LO] == OP_ILLEGAL;
   endfunction

   // The undefined opcode becomes nop; operand bits pass through untouched.
   function automatic logic [31:0] sanitise_cmd(input logic [31:0] cmd);
      logic [31:0] res;
      res = cmd;
      if (is_illegal(cmd)) res[OPC_HI:OPC_LO] = nop;
      return res;
   endfunction

   function automatic logic is_nop_pair(input cmd_pair_t p);
      return (p.a[OPC_HI:OPC_LO] == nop) && (p.b[OPC_HI:OPC_LO] == nop);
   endfunction

endpackage

// File: rtl/ats21_cmd_sequencer_if.sv
// Host command port and target half-word port of the ats21 command sequencer.
interface ats21_cmd_sequencer_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_a;
   logic [31:0] cmd_b;
   logic        req;
   logic [15:0] ctrlA;
   logic [15:0] ctrlB;
   logic        ready;

   modport master (
      output cmd_valid, cmd_a, cmd_b, ready,
      input  cmd_ready, req, ctrlA, ctrlB
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, ready,
      output cmd_ready, req, ctrlA, ctrlB
   );

endinterface

// File: rtl/ats21_cmd_fifo.sv
// Synchronous FIFO of command pairs; exposes the head and the entry behind it
// so the sequencer can chain pairs back-to-back.
module ats21_cmd_fifo
   import ats21_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      push_i,
   input  cmd_pair_t push_data_i,
   input  logic      pop_i,
   output logic      full_o,
   output logic      empty_o,
   output cmd_pair_t head_o,
   output cmd_pair_t next_o,
   output logic      has_next_o
);

   localparam int AW = $clog2(DEPTH);

   cmd_pair_t      mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q;
   logic [AW:0]    rd_ptr_q;
   logic [AW:0]    count;
   logic [AW-1:0]  rd_nxt;

   assign count      = wr_ptr_q - rd_ptr_q;
   assign full_o     = (count == (AW+1)'(DEPTH));
   assign empty_o    = (count == '0);
   assign has_next_o = (count > (AW+1)'(1));
   assign rd_nxt     = rd_ptr_q[AW-1:0] + AW'(1);
   assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
   assign next_o     = mem_q[rd_nxt];

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ats21_cmd_sequencer.sv
// Buffers sanitised command pairs and issues each as an upper then a lower
// 16-bit half under the target's req/ready handshake.
module ats21_cmd_sequencer
   import ats21_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter bit DROP_NOP = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   ats21_cmd_sequencer_if.slave   bus,
   output logic                   busy,
   output logic                   bad_op,
   input  logic                   clr_err,
   output logic [15:0]            issued_count
);

   seq_state_t  state_q, state_d;
   logic        req_q, req_d;
   logic [15:0] ctrl_a_q, ctrl_a_d;
   logic [15:0] ctrl_b_q, ctrl_b_d;
   logic [15:0] cnt_q, cnt_d;
   logic        bad_q, bad_d;

   logic        full, empty, has_next, push, pop;
   cmd_pair_t   push_pair, head, next;

   function automatic logic dropped(input cmd_pair_t p);
      return DROP_NOP && is_nop_pair(p);
   endfunction

   assign push      = bus.cmd_valid && !full;
   assign push_pair = '{a: sanitise_cmd(bus.cmd_a), b: sanitise_cmd(bus.cmd_b)};

   ats21_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (push),
      .push_data_i (push_pair),
      .pop_i       (pop),
      .full_o      (full),
      .empty_o     (empty),
      .head_o      (head),
      .next_o      (next),
      .has_next_o  (has_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         ctrl_a_q <= '0;
         ctrl_b_q <= '0;
         cnt_q    <= '0;
         bad_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         ctrl_a_q <= ctrl_a_d;
         ctrl_b_q <= ctrl_b_d;
         cnt_q    <= cnt_d;
         bad_q    <= bad_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      ctrl_a_d = ctrl_a_q;
      ctrl_b_d = ctrl_b_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;

      // A newly detected bad opcode outranks a simultaneous clear.
      bad_d = bad_q;
      if (clr_err) bad_d = 1'b0;
      if (push && (is_illegal(bus.cmd_a) || is_illegal(bus.cmd_b))) bad_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               if (dropped(head)) begin
                  pop = 1'b1;
               end else begin
                  req_d    = 1'b1;
                  ctrl_a_d = head.a[31:16];
                  ctrl_b_d = head.b[31:16];
                  state_d  = ST_UPPER;
               end
            end
         end
         ST_UPPER: begin
            if (bus.ready) begin
               ctrl_a_d = head.a[15:0];
               ctrl_b_d = head.b[15:0];
               state_d  = ST_LOWER;
            end
         end
         ST_LOWER: begin
            if (bus.ready) begin
               pop   = 1'b1;
               cnt_d = cnt_q + 16'd1;
               if (has_next && !dropped(next)) begin
                  ctrl_a_d = next.a[31:16];
                  ctrl_b_d = next.b[31:16];
                  state_d  = ST_UPPER;
               end else begin
                  req_d    = 1'b0;
                  ctrl_a_d = '0;
                  ctrl_b_d = '0;
                  state_d  = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.cmd_ready = !full;
   assign bus.req       = req_q;
   assign bus.ctrlA     = ctrl_a_q;
   assign bus.ctrlB     = ctrl_b_q;
   assign busy          = !empty || (state_q != ST_IDLE);
   assign bad_op        = bad_q;
   assign issued_count  = cnt_q;

endmodule

// File: tb/tb_ats21_cmd_sequencer.sv
// Directed bench for ats21_cmd_sequencer: reset, issue timing, stalls, FIFO
// full/back-to-back, opcode sanitising, nop dropping and mid-pair reset.
module tb_ats21_cmd_sequencer;
   import ats21_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        busy;
   logic        bad_op;
   logic        clr_err;
   logic [15:0] issued_count;
   int          checks = 0;
   int          errors = 0;

   ats21_cmd_sequencer_if bus();

   ats21_cmd_sequencer #(.DEPTH(4), .DROP_NOP(1'b1)) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .busy         (busy),
      .bad_op       (bad_op),
      .clr_err      (clr_err),
      .issued_count (issued_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b);
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      bus.ready     = 1'b0;
      clr_err       = 1'b0;
      bus.cmd_a     = 32'h2000_0001;
      bus.cmd_b     = 32'h8000_0000;
      bus.cmd_valid = 1'b1;
      do_reset();
      bus.cmd_valid = 1'b0;
      chk1 ("reset_req",       bus.req,       1'b0);
      chk16("reset_ctrlA",     bus.ctrlA,     16'h0000);
      chk16("reset_ctrlB",     bus.ctrlB,     16'h0000);
      chk1 ("reset_busy",      busy,          1'b0);
      chk1 ("reset_bad_op",    bad_op,        1'b0);
      chk16("reset_count",     issued_count,  16'h0000);
      chk1 ("reset_cmd_ready", bus.cmd_ready, 1'b1);
      tick();
      chk1 ("reset_idle_req",  bus.req,       1'b0);
   endtask

   task automatic test_single;
      do_reset();
      bus.ready = 1'b1;
      push(32'h2A40_1234, 32'h0000_0000);
      chk1 ("single_t0_req",   bus.req,      1'b0);
      chk1 ("single_t0_busy",  busy,         1'b1);
      tick();
      chk1 ("single_up_req",   bus.req,      1'b1);
      chk16("single_up_A",     bus.ctrlA,    16'h2A40);
      chk16("single_up_B",     bus.ctrlB,    16'h0000);
      tick();
      chk1 ("single_lo_req",   bus.req,      1'b1);
      chk16("single_lo_A",     bus.ctrlA,    16'h1234);
      chk16("single_lo_B",     bus.ctrlB,    16'h0000);
      tick();
      chk1 ("single_end_req",  bus.req,      1'b0);
      chk16("single_end_A",    bus.ctrlA,    16'h0000);
      chk16("single_count",    issued_count, 16'd1);
      chk1 ("single_end_busy", busy,         1'b0);
   endtask

   task automatic test_stall;
      do_reset();
      bus.ready = 1'b0;
      push(32'h2A40_1234, 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1 ("stall_req",   bus.req,   1'b1);
         chk16("stall_A",     bus.ctrlA, 16'h2A40);
      end
      bus.ready = 1'b1;
      tick();
      chk1 ("stall_lo_req", bus.req,   1'b1);
      chk16("stall_lo_A",   bus.ctrlA, 16'h1234);
      tick();
      chk1 ("stall_end_req", bus.req,      1'b0);
      chk16("stall_count",   issued_count, 16'd1);
   endtask

   task automatic test_back_to_back;
      logic [31:0] pa [4];
      logic [31:0] pb [4];
      logic [15:0] ea [8];
      logic [15:0] eb [8];
      pa = '{32'h20A0_1100, 32'h20A1_1101, 32'h20A2_1102, 32'h20A3_1103};
      pb = '{32'h4000_0B00, 32'h4001_0B01, 32'h4002_0B02, 32'h4003_0B03};
      ea = '{16'h20A0, 16'h1100, 16'h20A1, 16'h1101, 16'h20A2, 16'h1102, 16'h20A3, 16'h1103};
      eb = '{16'h4000, 16'h0B00, 16'h4001, 16'h0B01, 16'h4002, 16'h0B02, 16'h4003, 16'h0B03};
      do_reset();
      bus.ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk1("b2b_ready_before_push", bus.cmd_ready, 1'b1);
         push(pa[i], pb[i]);
      end
      chk1("b2b_full_ready", bus.cmd_ready, 1'b0);
      push(32'h6FFF_FFFF, 32'h6EEE_EEEE);
      chk1("b2b_refused_ready", bus.cmd_ready, 1'b0);
      bus.ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) tick();
         chk1 ("b2b_req", bus.req,   1'b1);
         chk16("b2b_A",   bus.ctrlA, ea[k]);
         chk16("b2b_B",   bus.ctrlB, eb[k]);
      end
      tick();
      chk1 ("b2b_end_req",  bus.req,      1'b0);
      chk16("b2b_count",    issued_count, 16'd4);
      chk1 ("b2b_end_busy", busy,         1'b0);
      tick();
      chk1 ("b2b_no_fifth", bus.req,      1'b0);
   endtask

   task automatic test_bad_op;
      do_reset();
      bus.ready = 1'b1;
      push(32'h8000_0001, 32'h2000_0002);
      chk1 ("bad_set",   bad_op,    1'b1);
      tick();
      chk1 ("bad_up_req", bus.req,  1'b1);
      chk16("bad_up_A",  bus.ctrlA, 16'h0000);
      chk16("bad_up_B",  bus.ctrlB, 16'h2000);
      tick();
      chk16("bad_lo_A",  bus.ctrlA, 16'h0001);
      tick();
      chk16("bad_count", issued_count, 16'd1);
      chk1 ("bad_sticky", bad_op,   1'b1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk1 ("bad_cleared", bad_op,  1'b0);
      clr_err = 1'b1;
      push(32'h3000_0000, 32'h9000_0000);
      clr_err = 1'b0;
      chk1 ("bad_set_wins", bad_op, 1'b1);
   endtask

   task automatic test_drop_nop;
      do_reset();
      bus.ready = 1'b1;
      push(32'h0000_1111, 32'h1FFF_0000);
      push(32'h2000_0055, 32'h0000_0066);
      chk1 ("drop_no_req", bus.req, 1'b0);
      tick();
      chk1 ("drop_up_req", bus.req,   1'b1);
      chk16("drop_up_A",   bus.ctrlA, 16'h2000);
      chk16("drop_up_B",   bus.ctrlB, 16'h0000);
      tick();
      chk16("drop_lo_A",   bus.ctrlA, 16'h0055);
      chk16("drop_lo_B",   bus.ctrlB, 16'h0066);
      tick();
      chk1 ("drop_end_req", bus.req,      1'b0);
      chk16("drop_count",   issued_count, 16'd1);
   endtask

   task automatic test_reset_mid;
      do_reset();
      bus.ready = 1'b0;
      push(32'h2A40_1234, 32'h4000_5678);
      tick();
      chk1 ("mid_up_req", bus.req, 1'b1);
      bus.ready = 1'b1;
      reset     = 1'b1;
      tick();
      reset = 1'b0;
      chk1 ("mid_req",       bus.req,       1'b0);
      chk1 ("mid_busy",      busy,          1'b0);
      chk1 ("mid_cmd_ready", bus.cmd_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk1("mid_no_lower", bus.req, 1'b0);
      end
      chk16("mid_count", issued_count, 16'd0);
   endtask

   initial begin
      reset         = 1'b1;
      clr_err       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.ready     = 1'b0;
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_bad_op();
      test_drop_nop();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ats21_cmd_sequencer.md
Name: ats21_cmd_sequencer

Overview:
- Upstream feeder for the ats21 alarm/timer block.
- Accepts paired 32-bit commands (channel A, channel B) from the test/host side, buffers them in a small FIFO and sanitises the opcodes.
- Drives the target's 16-bit req/ctrlA/ctrlB interface as two halves, upper half first, then lower half, under the target's ready handshake.

Parameters:
- DEPTH, 4, command-pair FIFO entries (power of 2, >=2).
- DROP_NOP, 1, when 1, a pair whose A and B opcodes are both nop is discarded without being issued.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command pair valid
- cmd_ready  out  1  FIFO can accept a pair
- cmd_a  in  32  channel A command ([31:29] opcode)
- cmd_b  in  32  channel B command ([31:29] opcode)
- req  out  1  half-word valid to target
- ctrlA  out  16  channel A half-word
- ctrlB  out  16  channel B half-word
- ready  in  1  target ready
- busy  out  1  FIFO non-empty or transfer in flight
- bad_op  out  1  sticky: undefined opcode seen
- clr_err  in  1  clears bad_op
- issued_count  out  16  completed pairs issued

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). Reset has priority over everything.
- Reset values: req=0, ctrlA=0, ctrlB=0, busy=0, bad_op=0, issued_count=0, FIFO empty, FSM in IDLE. cmd_ready follows the empty FIFO, so it reads 1 the cycle after reset deasserts.
- Reset mid-operation: a half-issued pair is lost. The lower half is never sent.
- Push: occurs on an edge with cmd_valid && cmd_ready. cmd_ready = !full, with no same-cycle bypass; a full FIFO refuses a push even while popping.
- Opcode sanitise at push:
  - Undefined opcode 3'b100 on A or B is rewritten to nop (3'b000) with other bits preserved.
  - bad_op is set on the next edge.
  - clr_err clears bad_op. If clr_err and a new bad opcode occur in the same cycle, set wins.
- Handshake rule: a half is accepted on an edge where req==1 && ready==1.
  - While req==1 and ready==0, req, ctrlA and ctrlB hold stable.
  - req never drops before acceptance.
- All outputs are registered.
- FSM:
  - IDLE: if FIFO non-empty and head pair is not dropped, load req=1, ctrlA=head_a[31:16], ctrlB=head_b[31:16], go to UPPER.
    - If the head is dropped (DROP_NOP=1 and both opcodes 000), pop it, stay in IDLE (1 cycle per drop).
  - UPPER: on acceptance, load ctrlA=head_a[15:0], ctrlB=head_b[15:0], keep req=1, go to LOWER.
  - LOWER: on acceptance, pop the head and increment issued_count.
    - If the next entry is issuable, load its upper half immediately (back-to-back, req stays 1) and go to UPPER.
    - Otherwise req=0, ctrl=0, go to IDLE.
- Latency: a pair pushed at edge t into an empty FIFO gives req=1 with the upper half after edge t+1. Minimum 2 cycles per issued pair.
- issued_count wraps 16'hFFFF -> 0.
- busy = !empty || state != IDLE.
- Simultaneous push and pop in the same cycle are both performed and the count is unchanged.

Decomposition:
- ats21_pkg holds:
  - opcode_t enum: nop=000, set_clk=001, clk_en=010, set_mode=011, set_alarm=101, set_timer=110, at_en=111.
  - Constants OPC_HI=31, OPC_LO=29 and OP_ILLEGAL=3'b100.
  - The 64-bit cmd_pair_t struct {a, b}.
  - The package is shared with the ats21 block and its bench.
- Sub-module ats21_cmd_fifo: a synchronous FIFO of cmd_pair_t, parameter DEPTH, with push/pop/full/empty/head and the same clk/reset.
- The FSM, sanitiser and counter live in ats21_cmd_sequencer.

Test Plan:
- Reset, then push A=32'h2A40_1234, B=32'h0000_0000 with ready=1 -> req=1 with ctrlA=16'h2A40, ctrlB=16'h0000 after edge t+1; then ctrlA=16'h1234; then req=0; issued_count=1.
- Same push with ready held 0 for 3 cycles while the upper half is presented -> ctrlA stays 16'h2A40 and req stays 1 for all 3 cycles; the lower half appears only after the acceptance edge.
- Push 4 pairs back-to-back (DEPTH=4) with ready=0 -> cmd_ready=0 after the 4th push and a 5th push is refused. Release ready -> 8 consecutive req cycles, halves in order, issued_count=4.
- Push A=32'h8000_0001 (opcode 100) -> bad_op=1 next cycle and ctrlA upper half=16'h0000. Pulse clr_err -> bad_op=0.
- DROP_NOP=1, push pair with both opcodes 000, then a set_clk pair -> nop pair never drives req, set_clk pair is issued, issued_count=1.
- Assert reset between the upper and lower half -> req=0 and busy=0 next cycle, FIFO empty, no lower half issued.
